// File: rtl/load_store_unit.sv
// Load/store unit between an RV32I core and a single-port word memory.
// Sub-word stores are done as read-modify-write; every access gives one response pulse.
module load_store_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDRESSLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDRESSLEN-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_error,
    output logic [ADDRESSLEN-1:0] mem_writeAddress,
    output logic [ADDRESSLEN-1:0] mem_readAddress,
    output logic [XLEN-1:0]       mem_data,
    output logic                  mem_writeEnabled,
    input  logic [XLEN-1:0]       mem_out
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDRESSLEN-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  write_q, write_d;
    logic [XLEN-1:0]       merge_q, merge_d;
    logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
    logic                  resp_error_q, resp_error_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  mem_we_q, mem_we_d;

    logic                  req_err;
    logic [4:0]            lane_sh;
    logic [XLEN-1:0]       rd_shift;
    logic [XLEN-1:0]       load_fmt;
    logic [XLEN-1:0]       lane_mask;
    logic [XLEN-1:0]       merged;

    // Illegal width code or misaligned halfword/word access
    always_comb begin
        req_err = 1'b0;
        if (req_write) begin
            if (!(req_funct3 inside {F3_B, F3_H, F3_W})) req_err = 1'b1;
        end else begin
            if (!(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) req_err = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    end

    // Little-endian lane extraction for loads and lane insertion for sub-word stores
    always_comb begin
        lane_sh  = {addr_q[1:0], 3'b000};
        rd_shift = mem_out >> lane_sh;
        case (funct3_q)
            F3_B:    load_fmt = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
            F3_H:    load_fmt = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            F3_BU:   load_fmt = XLEN'(rd_shift[7:0]);
            F3_HU:   load_fmt = XLEN'(rd_shift[15:0]);
            default: load_fmt = mem_out;
        endcase
        lane_mask = (funct3_q[1:0] == 2'b01) ? (XLEN'(16'hFFFF) << lane_sh)
                                             : (XLEN'(8'hFF) << lane_sh);
        merged    = (mem_out & ~lane_mask) | ((merge_q << lane_sh) & lane_mask);
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        write_d      = write_q;
        merge_d      = merge_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    write_d  = req_write;
                    merge_d  = req_wdata;
                    if (req_err) begin
                        state_d      = DONE;
                        resp_rdata_d = '0;
                        resp_error_d = 1'b1;
                    end else if (req_write && req_funct3 == F3_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    merge_d = merged;
                    state_d = WRITE;
                end else begin
                    resp_rdata_d = load_fmt;
                    resp_error_d = 1'b0;
                    state_d      = DONE;
                end
            end
            WRITE: begin
                resp_rdata_d = '0;
                resp_error_d = 1'b0;
                state_d      = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        resp_valid_d = (state_d == DONE);
        mem_we_d     = (state_d == WRITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            write_q      <= 1'b0;
            merge_q      <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            resp_valid_q <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            write_q      <= write_d;
            merge_q      <= merge_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            resp_valid_q <= resp_valid_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_error       = resp_error_q;
    assign mem_readAddress  = {addr_q[ADDRESSLEN-1:2], 2'b00};
    assign mem_writeAddress = {addr_q[ADDRESSLEN-1:2], 2'b00};
    assign mem_data         = merge_q;
    assign mem_writeEnabled = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, transaction-level reference and
// a per-cycle compare process, with directed and randomized accesses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_writeAddress;
    logic [31:0] mem_readAddress;
    logic [31:0] mem_data;
    logic        mem_writeEnabled;
    logic [31:0] mem_out;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .ADDRESSLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_writeAddress(mem_writeAddress), .mem_readAddress(mem_readAddress),
        .mem_data(mem_data), .mem_writeEnabled(mem_writeEnabled), .mem_out(mem_out)
    );

    logic [31:0] init_val [0:63];
    logic [31:0] mem      [0:63];
    logic [31:0] ref_mem  [0:63];

    // Data memory: preload while in reset, read on negedge, write on posedge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val[i];
        end else if (mem_writeEnabled) begin
            mem[mem_writeAddress[7:2]] <= mem_data;
        end
    end
    always @(negedge clk) mem_out <= mem[mem_readAddress[7:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    bit          chk_en = 1'b0;
    bit          active = 1'b0;
    int          acc, lat, wrel;
    logic [31:0] e_rdata, e_wdata, e_waddr;
    bit          e_err, e_chk_rdata;
    logic [31:0] hold_rdata;
    bit          hold_err, hold_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input int lane,
                                               input logic [2:0] f3);
        int unsigned b, h;
        b = (w >> (8 * lane)) & 32'hFF;
        h = (w >> (8 * lane)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Per-cycle comparison against the expectation of the transaction in flight
    always @(negedge clk) begin
        int rel;
        if (chk_en) begin
            if (active) begin
                rel = cyc - acc + 1;
                chk("busy_ready", req_ready, 0);
                chk("resp_valid", resp_valid, 32'(rel == lat));
                chk("write_strobe", mem_writeEnabled, 32'(rel == wrel));
                if (rel == wrel) begin
                    chk("write_addr", mem_writeAddress, e_waddr);
                    chk("write_data", mem_data, e_wdata);
                end
                if (rel == lat) begin
                    chk("resp_error", resp_error, e_err);
                    if (e_chk_rdata) chk("resp_rdata", resp_rdata, e_rdata);
                end
            end else begin
                chk("idle_ready", req_ready, 1);
                chk("idle_resp_valid", resp_valid, 0);
                chk("idle_strobe", mem_writeEnabled, 0);
                if (hold_valid) begin
                    chk("hold_rdata", resp_rdata, hold_rdata);
                    chk("hold_error", resp_error, hold_err);
                end
            end
        end
    end

    // One access: called #1 after a posedge with the unit idle
    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        logic [31:0] w;
        logic [7:0]  by [4];
        int          lane;
        bit          legal, err;
        w     = ref_mem[a[7:2]];
        lane  = int'(a[1:0]);
        legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err   = !legal || ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
        e_waddr     = {a[31:2], 2'b00};
        wrel        = -1;
        e_err       = err;
        e_chk_rdata = 1'b0;
        e_rdata     = '0;
        e_wdata     = '0;
        if (err) begin
            lat = 1; e_chk_rdata = 1'b1;
        end else if (!wr) begin
            lat = 2; e_rdata = model_load(w, lane, f3); e_chk_rdata = 1'b1;
        end else if (f3 == 3'd2) begin
            lat = 2; wrel = 1; e_wdata = wd;
            ref_mem[a[7:2]] = wd;
        end else begin
            lat = 3; wrel = 2;
            for (int k = 0; k < 4; k++) by[k] = w[8*k +: 8];
            by[lane] = wd[7:0];
            if (f3 == 3'd1) by[lane+1] = wd[15:8];
            e_wdata = {by[3], by[2], by[1], by[0]};
            ref_mem[a[7:2]] = e_wdata;
        end
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        acc    = cyc;
        active = 1'b1;
        // Noise while busy must be ignored
        req_valid  = 1'($urandom_range(0, 1));
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = 32'($urandom_range(0, 255));
        req_wdata  = $urandom;
        repeat (lat) @(posedge clk);
        #1;
        hold_valid = e_chk_rdata;
        hold_rdata = e_rdata;
        hold_err   = e_err;
        active     = 1'b0;
        req_valid  = 1'b0;
    endtask

    // SH accepted, then reset pulsed while the read is in progress
    task automatic do_abort(input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        chk("abort_busy", req_ready, 0);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        chk("abort_ready", req_ready, 1);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_strobe", mem_writeEnabled, 0);
        chk("abort_rdata", resp_rdata, 0);
        #1;
        rst = 1'b0;
        hold_valid = 1'b1; hold_rdata = '0; hold_err = 1'b0;
    endtask

    initial begin
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          t;
        for (int i = 0; i < 64; i++) begin
            init_val[i] = $urandom;
        end
        init_val[4] = 32'h8899AABB;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val[i];

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_error", resp_error, 0);
        chk("rst_strobe", mem_writeEnabled, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        hold_valid = 1'b1; hold_rdata = '0; hold_err = 1'b0;
        chk_en = 1'b1;

        do_req(0, 3'd0, 32'h11, 32'h0); chk("lb_0x11", resp_rdata, 32'hFFFFFFAA);
        do_req(0, 3'd4, 32'h11, 32'h0); chk("lbu_0x11", resp_rdata, 32'h000000AA);
        do_req(0, 3'd1, 32'h12, 32'h0); chk("lh_0x12", resp_rdata, 32'hFFFF8899);
        do_req(0, 3'd5, 32'h12, 32'h0); chk("lhu_0x12", resp_rdata, 32'h00008899);
        do_req(0, 3'd2, 32'h10, 32'h0); chk("lw_0x10", resp_rdata, 32'h8899AABB);
        do_req(1, 3'd0, 32'h12, 32'h12345677); chk("sb_mem", mem[4], 32'h8877AABB);
        do_req(1, 3'd2, 32'h20, 32'hDEADBEEF);
        do_req(0, 3'd2, 32'h20, 32'h0); chk("sw_lw_0x20", resp_rdata, 32'hDEADBEEF);
        do_req(0, 3'd2, 32'h22, 32'h0);
        chk("lw_mis_err", resp_error, 1); chk("lw_mis_rdata", resp_rdata, 0);
        do_req(1, 3'd1, 32'h13, 32'h5555);
        chk("sh_mis_err", resp_error, 1); chk("sh_mis_rdata", resp_rdata, 0);
        do_req(0, 3'd3, 32'h10, 32'h0);
        chk("ld_f3_011_err", resp_error, 1); chk("ld_f3_011_rdata", resp_rdata, 0);
        do_req(0, 3'd0, 32'h10, 32'h0); chk("err_clears", resp_error, 0);

        do_abort(32'h30, 32'h0000ABCD);
        do_req(0, 3'd2, 32'h30, 32'h0); chk("abort_mem_kept", resp_rdata, init_val[12]);

        for (int n = 0; n < 400; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 15) begin
                f3 = 3'($urandom);
            end else if (wr) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                t  = int'($urandom_range(0, 4));
                f3 = 3'((t > 2) ? t + 1 : t);
            end
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 70) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            do_req(wr, f3, a, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data word width.
REQ-002 SHALL have parameter ADDRESSLEN, default 32, meaning byte-address width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  1  core presents an access.
REQ-006 req_ready  output  1  unit idle, able to accept.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I width/sign code.
REQ-009 req_addr  input  ADDRESSLEN  byte address.
REQ-010 req_wdata  input  XLEN  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  XLEN  formatted load result.
REQ-013 resp_error  output  1  misaligned or illegal funct3, valid with resp_valid.
REQ-014 mem_writeAddress, mem_readAddress  output  ADDRESSLEN  word-aligned byte address to data memory.
REQ-015 mem_data  output  XLEN  write word; mem_writeEnabled  output  1  write strobe.
REQ-016 mem_out  input  XLEN  read word; memory captures it on negedge clk of the cycle the read address is driven.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE; req_ready=1 only in IDLE.
REQ-018 In IDLE with req_valid=1 at posedge: SHALL latch addr, funct3, wdata, write; next state per REQ-019..022.
REQ-019 Error (funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores; halfword with addr[0]=1; word with addr[1:0]!=0) -> DONE with resp_error=1, resp_rdata=0, no memory write.
REQ-020 Legal load -> READ; SW -> WRITE; SB/SH -> READ (read-modify-write).
REQ-021 READ: SHALL drive mem_readAddress={addr[ADDRESSLEN-1:2],2'b00}; at closing posedge sample mem_out; load -> format into resp_rdata, go DONE; SB/SH -> store merged word in internal register, go WRITE.
REQ-022 WRITE: SHALL assert mem_writeEnabled=1 for exactly one cycle, mem_writeAddress={addr[ADDRESSLEN-1:2],2'b00}, mem_data=full wdata (SW) or merged word (SB/SH); go DONE.
REQ-023 DONE: resp_valid=1 for exactly one cycle, then IDLE; resp_rdata/resp_error hold until next DONE.
REQ-024 mem_writeEnabled SHALL be 0 in every state except WRITE.
REQ-025 Lanes little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-026 LB/LH sign-extend, LBU/LHU zero-extend, LW passes word unchanged.
REQ-027 SB/SH merge: replace only the addressed lane(s) with wdata[7:0]/wdata[15:0]; other bytes keep the read value.
REQ-028 Latency, accept posedge = cycle 0: error resp_valid in cycle 1; load and SW in cycle 2; SB/SH in cycle 3.
REQ-029 req_valid outside IDLE SHALL be ignored; no queuing; the request is re-presented by the core.

Reset
REQ-030 rst=1 SHALL asynchronously force state IDLE, resp_valid=0, resp_rdata=0, resp_error=0, mem_writeEnabled=0, merge register 0.
REQ-031 rst asserted mid-operation (READ/WRITE) SHALL abort it: no write strobe after assertion, no response pulse.
REQ-032 First request SHALL be accepted at the first posedge after rst deasserts.

Verification
REQ-033 Memory word 0x10 = 0x8899AABB; LB addr 0x11 -> resp_rdata=0xFFFFFFAA, resp_valid in cycle 2; LBU addr 0x11 -> 0x000000AA.
REQ-034 LH addr 0x12 on same word -> 0xFFFF8899; LHU -> 0x00008899; LW addr 0x10 -> 0x8899AABB.
REQ-035 SB addr 0x12 wdata 0x12345677 on word 0x8899AABB -> one strobe in cycle 2, mem_data=0x8877AABB; resp_valid cycle 3.
REQ-036 SW addr 0x20 wdata 0xDEADBEEF -> strobe cycle 1 only; subsequent LW addr 0x20 returns 0xDEADBEEF.
REQ-037 LW addr 0x22, SH addr 0x13, load funct3 011 -> resp_error=1, resp_rdata=0 in cycle 1, mem_writeEnabled never 1.
REQ-038 SH issued, rst pulsed during READ -> no write, no resp_valid, memory unchanged, req_ready=1 immediately.
